// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage with a single outstanding imem request,
// an IF/ID pipeline register and a one-entry skid buffer for decode stalls.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cur_pc, nxt_pc        current PC and the value the PC register loads this edge
//   hazard_detected       decode stall (holds IF/ID)
//   flush                 taken branch/jump (squashes the fetched instruction)
//   imem_req, imem_addr   instruction memory request and word-aligned address
//   imem_ack, imem_rdata  instruction memory data-valid strobe and data
//   if_id_valid/instr/pc_plus_4  IF/ID register contents
//   fetch_stall           1 = hold the PC (ignored by the PC on a redirect)
//
// Optional feature macro: IFETCH_PERF_CNT_EN adds perf_fetch_cnt (IF/ID loads)
// and perf_stall_cnt (cycles with fetch_stall=1).
module ifetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cur_pc,
  input  logic [31:0] nxt_pc,
  input  logic        hazard_detected,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        fetch_stall
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic        r_flush_pending, w_flush_pending_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        w_load;
  logic [31:0] w_pc_plus_4;

  // Wraps naturally modulo 2^32.
  assign w_pc_plus_4 = r_req_addr + 32'd4;

  always_comb begin
    w_state_nxt         = r_state;
    w_req_addr_nxt      = r_req_addr;
    w_flush_pending_nxt = r_flush_pending;
    w_skid_instr_nxt    = r_skid_instr;
    w_skid_pc4_nxt      = r_skid_pc4;
    w_valid_nxt         = r_valid;
    w_instr_nxt         = r_instr;
    w_pc4_nxt           = r_pc4;
    w_load              = 1'b0;
    imem_req            = 1'b0;
    imem_addr           = 32'd0;
    fetch_stall         = 1'b1;

    unique case (r_state)
      StIdle: begin
        w_state_nxt    = StReq;
        w_req_addr_nxt = cur_pc;
        if (flush) w_valid_nxt = 1'b0;
      end
      StReq: begin
        imem_req    = 1'b1;
        imem_addr   = {r_req_addr[31:2], 2'b00};
        fetch_stall = !(imem_ack && !hazard_detected && !r_flush_pending);
        if (imem_ack) begin
          if (flush) begin
            // Redirect wins over everything, including a stale pending flush.
            w_valid_nxt         = 1'b0;
            w_flush_pending_nxt = 1'b0;
            w_req_addr_nxt      = nxt_pc;
          end else if (r_flush_pending) begin
            // Data belongs to the squashed path; refetch from the redirected PC.
            w_flush_pending_nxt = 1'b0;
            w_req_addr_nxt      = cur_pc;
          end else if (hazard_detected) begin
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc4_nxt   = w_pc_plus_4;
            w_state_nxt      = StHold;
          end else begin
            w_valid_nxt    = 1'b1;
            w_instr_nxt    = imem_rdata;
            w_pc4_nxt      = w_pc_plus_4;
            w_req_addr_nxt = nxt_pc;
            w_load         = 1'b1;
          end
        end else if (flush) begin
          // Request cannot be withdrawn; remember to discard its data.
          w_flush_pending_nxt = 1'b1;
          w_valid_nxt         = 1'b0;
        end
      end
      StHold: begin
        if (flush) begin
          w_valid_nxt      = 1'b0;
          w_skid_instr_nxt = 32'd0;
          w_skid_pc4_nxt   = 32'd0;
          w_req_addr_nxt   = nxt_pc;
          w_state_nxt      = StReq;
        end else if (!hazard_detected) begin
          w_valid_nxt    = 1'b1;
          w_instr_nxt    = r_skid_instr;
          w_pc4_nxt      = r_skid_pc4;
          w_req_addr_nxt = nxt_pc;
          w_state_nxt    = StReq;
          w_load         = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_req_addr      <= 32'd0;
      r_flush_pending <= 1'b0;
      r_skid_instr    <= 32'd0;
      r_skid_pc4      <= 32'd0;
      r_valid         <= 1'b0;
      r_instr         <= 32'd0;
      r_pc4           <= 32'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_req_addr      <= w_req_addr_nxt;
      r_flush_pending <= w_flush_pending_nxt;
      r_skid_instr    <= w_skid_instr_nxt;
      r_skid_pc4      <= w_skid_pc4_nxt;
      r_valid         <= w_valid_nxt;
      r_instr         <= w_instr_nxt;
      r_pc4           <= w_pc4_nxt;
    end
  end

  assign if_id_valid     = r_valid;
  assign if_id_instr     = r_instr;
  assign if_id_pc_plus_4 = r_pc4;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_load)      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (fetch_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  logic w_unused;
  assign w_unused = w_load;
`endif

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-002 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port cur_pc, input, 32, the current PC register value.
REQ-004 The block SHALL have port nxt_pc, input, 32, the next-PC mux value that the PC register loads on this edge.
REQ-005 The block SHALL have port hazard_detected, input, 1, the decode stall that holds IF/ID.
REQ-006 The block SHALL have port flush, input, 1, the taken branch/jump that squashes the fetched instruction.
REQ-007 The block SHALL have port imem_req, output, 1, the instruction memory request.
REQ-008 The block SHALL have port imem_addr, output, 32, the word-aligned fetch address.
REQ-009 The block SHALL have port imem_ack, input, 1, the instruction memory data-valid strobe.
REQ-010 The block SHALL have port imem_rdata, input, 32, the instruction word, sampled only when imem_ack=1.
REQ-011 The block SHALL have port if_id_valid, output, 1, marking the IF/ID contents as a live instruction.
REQ-012 The block SHALL have ports if_id_instr (output, 32) and if_id_pc_plus_4 (output, 32), holding the IF/ID payload.
REQ-013 The block SHALL have port fetch_stall, output, 1; at 1 the PC is held, except on a redirect.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and HOLD.
REQ-015 IDLE SHALL go to REQ after one cycle, loading req_addr from cur_pc.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL be {req_addr[31:2],2'b00}, with the address held stable until imem_ack.
REQ-017 In IDLE and HOLD, imem_req SHALL be 0 and imem_addr SHALL be 0.
REQ-018 fetch_stall SHALL be 0 only when state==REQ && imem_ack && !hazard_detected && !flush_pending.
REQ-019 On REQ && imem_ack && !hazard && !flush && !flush_pending: IF/ID SHALL load {valid=1, imem_rdata, req_addr+4}, req_addr SHALL load nxt_pc, and the FSM SHALL stay in REQ; minimum fetch latency is 1 cycle from req to IF/ID valid.
REQ-020 On REQ && imem_ack && hazard && !flush: imem_rdata and req_addr+4 SHALL go to a skid register, IF/ID SHALL hold, and the FSM SHALL go to HOLD.
REQ-021 In HOLD with !hazard: the skid contents SHALL move into IF/ID with valid=1, req_addr SHALL load nxt_pc, and the FSM SHALL go to REQ.
REQ-022 flush SHALL have priority over hazard: if_id_valid SHALL clear on the next edge and the skid SHALL be dropped.
REQ-023 flush in HOLD or on an ack cycle SHALL load req_addr from nxt_pc and go to REQ.
REQ-024 flush in REQ without ack SHALL set flush_pending while the request continues; the acked data SHALL be discarded, flush_pending SHALL clear, and req_addr SHALL load cur_pc.
REQ-025 req_addr+4 SHALL wrap modulo 2^32 (0xFFFFFFFC gives 0x00000000).
REQ-026 if_id_instr and if_id_pc_plus_4 SHALL change only on an IF/ID load; a flush SHALL clear valid only.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: state=IDLE, imem_req=0, imem_addr=0, fetch_stall=1, if_id_valid=0, if_id_instr=0, if_id_pc_plus_4=0, req_addr=0, skid=0, flush_pending=0.
REQ-028 Reset during an outstanding request SHALL abandon it; an imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-029 With IFETCH_PERF_CNT_EN defined, the block SHALL have two 32-bit output ports: perf_fetch_cnt (+1 per IF/ID load with valid=1) and perf_stall_cnt (+1 per cycle with fetch_stall=1), both reset to 0, wrapping, and updating only when rst_n=1.
REQ-030 With IFETCH_PERF_CNT_EN undefined, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: reset release, cur_pc=0, ack on the first REQ cycle with rdata=0x20080005 -> imem_addr=0 in REQ; next cycle if_id_valid=1, if_id_instr=0x20080005, if_id_pc_plus_4=4.
REQ-032 The bench SHALL cover: ack held off 3 cycles at addr 0x40 -> imem_req=1 and imem_addr=0x40 stable for 4 cycles, fetch_stall=1 for 3 cycles then 0 on the ack cycle.
REQ-033 The bench SHALL cover: hazard=1 on the ack cycle (rdata=0xAAAA0000), hazard then held 2 more cycles -> IF/ID unchanged for 3 cycles, state=HOLD; on hazard drop, IF/ID=0xAAAA0000 with valid=1.
REQ-034 The bench SHALL cover: flush in REQ without ack, ack 2 cycles later with cur_pc=0x100 -> no IF/ID load, and the next imem_addr=0x100.
REQ-035 The bench SHALL cover: req_addr=0xFFFFFFFC acked -> if_id_pc_plus_4=0x00000000.
REQ-036 The bench SHALL cover: rst_n asserted mid-REQ then released with ack pulsed during reset -> all outputs at reset values, if_id_valid=0, and the counters (if enabled) equal 0.
